// File: rtl/onehot_seq.sv
// Step sequencer that walks either a one-hot ring (with an all-zero slot) or a Johnson code,
// flagging wraps back to zero and any step taken from a code that is illegal in the active mode.
module onehot_seq #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output logic             wrap,
    output logic [CNT_W-1:0] wrap_cnt,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MSB     = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] inv_state;
    logic [WIDTH-1:0] next_state;
    logic             legal;

    assign inv_state = ~state;

    // Johnson codes are a run of ones anchored at bit0 (x & (x+1) == 0) or at the MSB (same test on ~x).
    always_comb begin
        legal      = 1'b0;
        next_state = '0;
        if (!mode) begin
            legal = ((state & (state - ONE)) == '0);
            if (state == '0)
                next_state = dir ? MSB : ONE;
            else
                next_state = dir ? (state >> 1) : (state << 1);
        end else begin
            legal = ((state & (state + ONE)) == '0) ||
                    ((inv_state & (inv_state + ONE)) == '0);
            next_state = dir ? {~state[0], state[WIDTH-1:1]}
                             : {state[WIDTH-2:0], ~state[WIDTH-1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= '0;
            wrap     <= 1'b0;
            wrap_cnt <= '0;
            err      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load) begin
                state <= load_val;
            end else if (en) begin
                if (!legal) begin
                    state <= '0;
                    err   <= 1'b1;
                end else begin
                    state <= next_state;
                    if (state != '0 && next_state == '0) begin
                        wrap <= 1'b1;
                        if (wrap_cnt != '1)
                            wrap_cnt <= wrap_cnt + CNT_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_onehot_seq.sv
// Scoreboard bench for onehot_seq: the driver pushes hand-computed expectations per edge,
// a monitor pops and compares them one time unit after each rising edge.
module tb_onehot_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       mode;
    logic       dir;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] state;
    logic       wrap;
    logic [1:0] wrap_cnt;
    logic       err;

    typedef struct packed {
        logic [3:0] st;
        logic       wr;
        logic [1:0] cnt;
        logic       er;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   vectors     = 0;
    int   miscompares = 0;

    logic [3:0] up_seq   [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};
    logic [3:0] down_seq [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
    logic [3:0] john_up  [8] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111,
                                 4'b1110, 4'b1100, 4'b1000, 4'b0000};
    logic [3:0] john_dn  [8] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111,
                                 4'b0111, 4'b0011, 4'b0001, 4'b0000};
    logic [1:0] sat_prev [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
    logic [1:0] sat_wrap [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    onehot_seq #(.WIDTH(4), .CNT_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .mode     (mode),
        .dir      (dir),
        .load     (load),
        .load_val (load_val),
        .state    (state),
        .wrap     (wrap),
        .wrap_cnt (wrap_cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    // Called on a falling edge: drives one edge's inputs, queues its expected result, moves on a cycle.
    task automatic applyStimulus(input logic l, input logic e, input logic m, input logic d,
                                 input logic [3:0] lv, input logic [3:0] st, input logic wr,
                                 input logic [1:0] cnt, input logic er);
        exp_t x;
        load = l; en = e; mode = m; dir = d; load_val = lv;
        x.st = st; x.wr = wr; x.cnt = cnt; x.er = er;
        sb.push_back(x);
        @(negedge clk);
    endtask

    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            checkOutput("state", state, mon_x.st);
            checkOutput("wrap", wrap, mon_x.wr);
            checkOutput("wrap_cnt", wrap_cnt, mon_x.cnt);
            checkOutput("err", err, mon_x.er);
        end
    end

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b0; dir = 1'b0; load = 1'b0; load_val = 4'h0;
        #1;
        checkOutput("reset_state", state, 0);
        checkOutput("reset_wrap", wrap, 0);
        checkOutput("reset_cnt", wrap_cnt, 0);
        checkOutput("reset_err", err, 0);
        @(negedge clk);
        rst = 1'b0;

        // One-hot ring toward MSB straight out of reset
        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 0, 0, 4'h0, up_seq[i], (i == 4), (i == 4) ? 2'd1 : 2'd0, 0);
        applyStimulus(0, 0, 0, 0, 4'h0, 4'b0000, 0, 2'd1, 0);

        // Illegal load then step, err sticks
        applyStimulus(1, 0, 0, 0, 4'b0101, 4'b0101, 0, 2'd1, 0);
        applyStimulus(0, 1, 0, 0, 4'h0, 4'b0000, 0, 2'd1, 1);
        applyStimulus(0, 1, 0, 0, 4'h0, 4'b0001, 0, 2'd1, 1);

        // Johnson code loaded, stepped both ways, then stepped as mode 0 where it is illegal
        applyStimulus(1, 0, 1, 0, 4'b0011, 4'b0011, 0, 2'd1, 1);
        applyStimulus(0, 1, 1, 0, 4'h0, 4'b0111, 0, 2'd1, 1);
        applyStimulus(0, 1, 1, 1, 4'h0, 4'b0011, 0, 2'd1, 1);
        applyStimulus(0, 1, 0, 0, 4'h0, 4'b0000, 0, 2'd1, 1);

        for (int i = 0; i < 5; i++)
            applyStimulus(0, 1, 0, 1, 4'h0, down_seq[i], (i == 4), (i == 4) ? 2'd2 : 2'd1, 1);

        // Direction change mid-sequence
        applyStimulus(0, 1, 0, 0, 4'h0, 4'b0001, 0, 2'd2, 1);
        applyStimulus(0, 1, 0, 0, 4'h0, 4'b0010, 0, 2'd2, 1);
        applyStimulus(0, 1, 0, 1, 4'h0, 4'b0001, 0, 2'd2, 1);
        applyStimulus(0, 1, 0, 1, 4'h0, 4'b0000, 1, 2'd3, 1);

        // Load beats en on the same edge; loading zero is never a wrap
        applyStimulus(1, 1, 0, 0, 4'b1010, 4'b1010, 0, 2'd3, 1);
        applyStimulus(0, 0, 0, 0, 4'h0, 4'b1010, 0, 2'd3, 1);
        applyStimulus(1, 1, 0, 0, 4'b0000, 4'b0000, 0, 2'd3, 1);

        // Asynchronous reset between edges at state 0100
        applyStimulus(0, 1, 0, 0, 4'h0, 4'b0001, 0, 2'd3, 1);
        applyStimulus(0, 1, 0, 0, 4'h0, 4'b0010, 0, 2'd3, 1);
        applyStimulus(0, 1, 0, 0, 4'h0, 4'b0100, 0, 2'd3, 1);
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        checkOutput("async_rst_state", state, 0);
        checkOutput("async_rst_wrap", wrap, 0);
        checkOutput("async_rst_cnt", wrap_cnt, 0);
        checkOutput("async_rst_err", err, 0);
        @(negedge clk);
        applyStimulus(0, 1, 0, 0, 4'h0, 4'b0000, 0, 2'd0, 0);
        rst = 1'b0;

        // Five wraps against a 2-bit saturating counter
        for (int w = 0; w < 5; w++)
            for (int i = 0; i < 5; i++)
                applyStimulus(0, 1, 0, 0, 4'h0, up_seq[i], (i == 4),
                              (i == 4) ? sat_wrap[w] : sat_prev[w], 0);

        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 1, 0, 4'h0, john_up[i], (i == 7), 2'd3, 0);
        for (int i = 0; i < 8; i++)
            applyStimulus(0, 1, 1, 1, 4'h0, john_dn[i], (i == 7), 2'd3, 0);

        // Non-Johnson pattern stepped in mode 1
        applyStimulus(1, 0, 1, 0, 4'b0101, 4'b0101, 0, 2'd3, 0);
        applyStimulus(0, 1, 1, 0, 4'h0, 4'b0000, 0, 2'd3, 1);
        applyStimulus(0, 0, 1, 0, 4'h0, 4'b0000, 0, 2'd3, 1);

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        miscompares++;
        $display("[TB] FAIL watchdog: got timeout, required completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/onehot_seq.md
ONEHOT_SEQ -- requirements
Module: onehot_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, sequence register width, legal range 2..32.
REQ-002 The block SHALL have parameter CNT_W, default 8, wrap-counter width, legal range 1..16.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 The block SHALL have port en, input, 1, advance the sequence one step.
REQ-006 The block SHALL have port mode, input, 1, sequence mode: 0 = one-hot ring with zero, 1 = Johnson.
REQ-007 The block SHALL have port dir, input, 1, step direction: 0 = toward MSB, 1 = toward LSB.
REQ-008 The block SHALL have port load, input, 1, parallel load strobe.
REQ-009 The block SHALL have port load_val, input, WIDTH, value written on load.
REQ-010 The block SHALL have port state, output, WIDTH, current sequence register.
REQ-011 The block SHALL have port wrap, output, 1, registered one-cycle pulse on sequence wrap.
REQ-012 The block SHALL have port wrap_cnt, output, CNT_W, saturating count of wraps.
REQ-013 The block SHALL have port err, output, 1, sticky illegal-state flag.

Function
REQ-014 Per-edge priority SHALL be: load, then en, then hold; en=0 and load=0 leaves state, wrap_cnt and err unchanged, and wrap = 0.
REQ-015 On load, state SHALL take load_val unchanged on the next edge; wrap = 0; no legality check at load time.
REQ-016 In mode 0, legal states SHALL be all-zero or exactly one bit set.
REQ-017 In mode 0 with dir=0, a step SHALL go 0 -> bit0 -> bit1 -> ... -> bit WIDTH-1 -> 0, giving period WIDTH+1.
REQ-018 In mode 0 with dir=1, a step SHALL go 0 -> bit WIDTH-1 -> ... -> bit0 -> 0.
REQ-019 In mode 1, legal states SHALL be the 2*WIDTH Johnson codes: a contiguous run of ones anchored at bit0 or at bit WIDTH-1, including all-zero and all-ones.
REQ-020 In mode 1 with dir=0, the next state SHALL be {state[WIDTH-2:0], ~state[WIDTH-1]}.
REQ-021 In mode 1 with dir=1, the next state SHALL be {~state[0], state[WIDTH-1:1]}; period is 2*WIDTH.
REQ-022 A wrap SHALL be an en-step from a nonzero legal state to all-zero; wrap is asserted on the same edge state becomes 0.
REQ-023 wrap_cnt SHALL increment by 1 on each wrap and saturate at 2^CNT_W-1, with no rollover.
REQ-024 An en-step taken while state is illegal for the current mode SHALL set state to 0 and set err = 1, with wrap = 0 and wrap_cnt unchanged.
REQ-025 Legality SHALL be evaluated against the mode value at the current edge; a mode switch mid-sequence is legal if the state is legal in the new mode, otherwise REQ-024 applies.
REQ-026 dir MAY change on any cycle; the next step SHALL use the new direction from the current state.
REQ-027 err SHALL be sticky: it clears only on rst.
REQ-028 While in mode 0 with no illegal load, state SHALL always satisfy onehot0.

Reset
REQ-029 While rst = 1, state SHALL be 0, wrap 0, wrap_cnt 0 and err 0, asynchronously with no clock edge required.
REQ-030 After rst deasserts, the first edge SHALL behave per REQ-014; there is no extra latency cycle.

Verification
REQ-031 Scenario (WIDTH=4, mode=0, dir=0, en=1 from reset): state SHALL go 0000,0001,0010,0100,1000,0000; wrap pulses only on the 5th edge; wrap_cnt becomes 1.
REQ-032 Scenario (mode=0, dir=1): state SHALL go 0000,1000,0100,0010,0001,0000; wrap on the 5th edge.
REQ-033 Scenario (mode=1, dir=0): state SHALL go 0000,0001,0011,0111,1111,1110,1100,1000,0000; wrap only on the 8th edge.
REQ-034 Scenario (mode=0, load 0101, then en=1): state SHALL be 0101 after the load edge, then 0000 with err=1 and wrap=0; err stays 1 until rst.
REQ-035 Scenario (CNT_W=2, 5 mode-0 wraps): wrap_cnt SHALL read 1,2,3,3,3; wrap pulses all 5 times.
REQ-036 Scenario (rst asserted mid-sequence at state 0100, between edges; load=1 and en=1 on the same edge at another time): rst SHALL zero all outputs immediately, and the simultaneous load/en edge SHALL take load_val.
